// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: WBsel sources, load/store
// size codes, access-size classes and the bus FSM state type.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_PC4  = 2'b10,
    WB_ALU2 = 2'b11
  } wbsel_e;

  localparam logic [2:0] RSEL_LB  = 3'b000;
  localparam logic [2:0] RSEL_LH  = 3'b001;
  localparam logic [2:0] RSEL_LW  = 3'b010;
  localparam logic [2:0] RSEL_LBU = 3'b100;
  localparam logic [2:0] RSEL_LHU = 3'b101;

  localparam logic [1:0] WSEL_BYTE = 2'b00;
  localparam logic [1:0] WSEL_HALF = 2'b01;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } acc_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } mem_state_e;

  // A half must sit on an even address, a word on a multiple of four.
  function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: is_misaligned = lo[0];
      SZ_WORD: is_misaligned = |lo;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half lane out of a read word and sign- or
// zero-extends it according to the load funct3 code.
module mem_load_align
  import mem_stage_pkg::*;
#(
  parameter int datawidth = 32
) (
  input  logic [datawidth-1:0] rdata,
  input  logic [1:0]           addr_lo,
  input  logic [2:0]           rsel,
  output logic [datawidth-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane extraction followed by extension; unknown codes behave as a word load.
  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    half_v = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (rsel)
      RSEL_LB:  data = {{(datawidth-8){byte_v[7]}}, byte_v};
      RSEL_LH:  data = {{(datawidth-16){half_v[15]}}, half_v};
      RSEL_LBU: data = {{(datawidth-8){1'b0}}, byte_v};
      RSEL_LHU: data = {{(datawidth-16){1'b0}}, half_v};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues data-memory requests through a two-state
// handshake FSM, stalls upstream while waiting, and loads MEM/WB.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned halves/words are
// suppressed and flagged on misalign_err instead of being truncated.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int datawidth = 32,
  parameter int regindex  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [datawidth-1:0] ALU_in,
  input  logic [datawidth-1:0] datareg_in,
  input  logic [datawidth-1:0] pcm_in,
  input  logic [regindex-1:0]  regdindex_in,
  input  logic [1:0]           WBsel_in,
  input  logic                 MEMRw_in,
  input  logic [2:0]           Rsel_in,
  input  logic [1:0]           Wsel_in,
  input  logic                 Regwrite_in,
  output logic                 mem_stall,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [datawidth-1:0] dmem_addr,
  output logic [datawidth-1:0] dmem_wdata,
  output logic [3:0]           dmem_be,
  input  logic                 dmem_ack,
  input  logic [datawidth-1:0] dmem_rdata,
  output logic [datawidth-1:0] wb_data_out,
  output logic [regindex-1:0]  regdindex_out,
  output logic                 Regwrite_out,
  output logic                 misalign_err
);

  mem_state_e             state, state_next;
  acc_size_e              acc_size;
  logic                   memop, mis_trap, memop_go, mis_q;
  logic [3:0]             be_next;
  logic [datawidth-1:0]   wdata_next, load_data, wb_sel_data;

  assign memop = (WBsel_in == WB_MEM) | MEMRw_in;

  // Access size comes from the store size for stores, from funct3 for loads.
  always_comb begin
    acc_size = SZ_WORD;
    if (MEMRw_in) begin
      case (Wsel_in)
        WSEL_BYTE: acc_size = SZ_BYTE;
        WSEL_HALF: acc_size = SZ_HALF;
        default:   acc_size = SZ_WORD;
      endcase
    end else begin
      case (Rsel_in)
        RSEL_LB, RSEL_LBU: acc_size = SZ_BYTE;
        RSEL_LH, RSEL_LHU: acc_size = SZ_HALF;
        default:           acc_size = SZ_WORD;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_trap = memop & is_misaligned(acc_size, ALU_in[1:0]);
`else
  assign mis_trap = 1'b0;
`endif

  assign memop_go     = memop & ~mis_trap;
  assign misalign_err = mis_q;

  // Byte enables and lane-replicated write data; half uses only addr[1] so odd
  // addresses fall back to natural alignment.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = datareg_in;
    if (MEMRw_in) begin
      case (acc_size)
        SZ_BYTE: begin
          be_next    = 4'b0001 << ALU_in[1:0];
          wdata_next = {(datawidth/8){datareg_in[7:0]}};
        end
        SZ_HALF: begin
          be_next    = 4'b0011 << {ALU_in[1], 1'b0};
          wdata_next = {(datawidth/16){datareg_in[15:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = datareg_in;
        end
      endcase
    end
  end

  // Next state and stall: stall on the issue cycle and every unacked REQ cycle.
  always_comb begin
    state_next = state;
    mem_stall  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (memop_go) begin
          state_next = ST_REQ;
          mem_stall  = 1'b1;
        end
      end
      ST_REQ: begin
        if (dmem_ack) state_next = ST_IDLE;
        else          mem_stall  = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Request registers: captured on REQ entry and held until the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= 4'b0000;
    end else if (state == ST_IDLE && memop_go) begin
      dmem_req   <= 1'b1;
      dmem_we    <= MEMRw_in;
      dmem_addr  <= {ALU_in[datawidth-1:2], 2'b00};
      dmem_wdata <= wdata_next;
      dmem_be    <= be_next;
    end else if (state == ST_REQ && dmem_ack) begin
      dmem_req   <= 1'b0;
    end
  end

  mem_load_align #(.datawidth(datawidth)) u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (ALU_in[1:0]),
    .rsel    (Rsel_in),
    .data    (load_data)
  );

  // Writeback source selection.
  always_comb begin
    case (WBsel_in)
      WB_MEM:  wb_sel_data = load_data;
      WB_PC4:  wb_sel_data = pcm_in;
      default: wb_sel_data = ALU_in;
    endcase
  end

  // MEM/WB register: loads when not stalled, otherwise a bubble with data held.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_out   <= '0;
      regdindex_out <= '0;
      Regwrite_out  <= 1'b0;
      mis_q         <= 1'b0;
    end else if (mem_stall) begin
      Regwrite_out  <= 1'b0;
      mis_q         <= 1'b0;
    end else begin
      wb_data_out   <= wb_sel_data;
      regdindex_out <= regdindex_in;
      Regwrite_out  <= Regwrite_in & (regdindex_in != '0) & ~mis_trap;
      mis_q         <= mis_trap;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; expectations for misaligned accesses
// follow whether MEM_MISALIGN_TRAP_EN is defined for the build.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALU_in, datareg_in, pcm_in;
  logic [4:0]  regdindex_in;
  logic [1:0]  WBsel_in;
  logic        MEMRw_in;
  logic [2:0]  Rsel_in;
  logic [1:0]  Wsel_in;
  logic        Regwrite_in;
  logic        mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] wb_data_out;
  logic [4:0]  regdindex_out;
  logic        Regwrite_out, misalign_err;

  int total = 0;
  int bad   = 0;

  mem_access_stage #(.datawidth(32), .regindex(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .ALU_in        (ALU_in),
    .datareg_in    (datareg_in),
    .pcm_in        (pcm_in),
    .regdindex_in  (regdindex_in),
    .WBsel_in      (WBsel_in),
    .MEMRw_in      (MEMRw_in),
    .Rsel_in       (Rsel_in),
    .Wsel_in       (Wsel_in),
    .Regwrite_in   (Regwrite_in),
    .mem_stall     (mem_stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_be       (dmem_be),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .wb_data_out   (wb_data_out),
    .regdindex_out (regdindex_out),
    .Regwrite_out  (Regwrite_out),
    .misalign_err  (misalign_err)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] wbsel, input logic memrw,
                               input logic [2:0] rsel, input logic [1:0] wsel,
                               input logic [31:0] alu, input logic [31:0] dreg,
                               input logic [31:0] pcm, input logic [4:0] regd,
                               input logic regwr);
    WBsel_in     = wbsel;
    MEMRw_in     = memrw;
    Rsel_in      = rsel;
    Wsel_in      = wsel;
    ALU_in       = alu;
    datareg_in   = dreg;
    pcm_in       = pcm;
    regdindex_in = regd;
    Regwrite_in  = regwr;
  endtask

  task automatic applyNop();
    applyStimulus(2'b00, 1'b0, 3'b010, 2'b10, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    applyNop();
    tick();
    tick();

    checkOutput("rst_req",   dmem_req,      0);
    checkOutput("rst_wb",    wb_data_out,   0);
    checkOutput("rst_rw",    Regwrite_out,  0);
    checkOutput("rst_regd",  regdindex_out, 0);
    checkOutput("rst_stall", mem_stall,     0);
    checkOutput("rst_mis",   misalign_err,  0);
    checkOutput("rst_be",    dmem_be,       0);
    checkOutput("rst_addr",  dmem_addr,     0);
    rst = 1'b0;

    $display("[TB] ALU / PC+4 writeback");
    applyStimulus(2'b00, 1'b0, 3'b010, 2'b10, 32'h1234, 32'h0, 32'h4, 5'd5, 1'b1);
    #1 checkOutput("alu_stall", mem_stall, 0);
    tick();
    checkOutput("alu_wb",    wb_data_out,   32'h1234);
    checkOutput("alu_rw",    Regwrite_out,  1);
    checkOutput("alu_regd",  regdindex_out, 5);
    checkOutput("alu_stall2", mem_stall,    0);

    applyStimulus(2'b10, 1'b0, 3'b010, 2'b10, 32'h77, 32'h0, 32'h88, 5'd7, 1'b1);
    tick();
    checkOutput("pc4_wb",   wb_data_out,   32'h88);
    checkOutput("pc4_regd", regdindex_out, 7);

    applyStimulus(2'b11, 1'b0, 3'b010, 2'b10, 32'h55, 32'h0, 32'h99, 5'd0, 1'b1);
    tick();
    checkOutput("alu11_wb", wb_data_out,  32'h55);
    checkOutput("x0_rw",    Regwrite_out, 0);

    $display("[TB] LB with three wait cycles");
    applyStimulus(2'b01, 1'b0, 3'b000, 2'b00, 32'h1003, 32'h0, 32'h0, 5'd3, 1'b1);
    dmem_rdata = 32'h80FFFFFF;
    for (int k = 0; k < 4; k++) begin
      #1 checkOutput("lb_stall", mem_stall, 1);
      if (k == 0) begin
        checkOutput("lb_req_idle", dmem_req, 0);
      end else begin
        checkOutput("lb_req",    dmem_req,     1);
        checkOutput("lb_addr",   dmem_addr,    32'h1000);
        checkOutput("lb_we",     dmem_we,      0);
        checkOutput("lb_bubble", Regwrite_out, 0);
      end
      tick();
    end
    dmem_ack = 1'b1;
    #1 checkOutput("lb_ack_stall", mem_stall, 0);
    tick();
    dmem_ack = 1'b0;
    applyNop();
    checkOutput("lb_wb",   wb_data_out,   32'hFFFFFF80);
    checkOutput("lb_rw",   Regwrite_out,  1);
    checkOutput("lb_regd", regdindex_out, 3);
    checkOutput("lb_req_done", dmem_req,  0);

    $display("[TB] SB / SH with same-cycle ack");
    applyStimulus(2'b00, 1'b1, 3'b000, 2'b00, 32'h2002, 32'h000000AB, 32'h0, 5'd0, 1'b0);
    #1 checkOutput("sb_stall", mem_stall, 1);
    checkOutput("sb_req_idle", dmem_req, 0);
    tick();
    checkOutput("sb_req",   dmem_req,   1);
    checkOutput("sb_be",    dmem_be,    4'b0100);
    checkOutput("sb_wdata", dmem_wdata, 32'hABABABAB);
    checkOutput("sb_addr",  dmem_addr,  32'h2000);
    checkOutput("sb_we",    dmem_we,    1);
    dmem_ack = 1'b1;
    #1 checkOutput("sb_ack_stall", mem_stall, 0);
    tick();
    dmem_ack = 1'b0;
    applyNop();
    checkOutput("sb_rw",  Regwrite_out, 0);
    checkOutput("sb_req_done", dmem_req, 0);

    applyStimulus(2'b00, 1'b1, 3'b000, 2'b01, 32'h2006, 32'h00001234, 32'h0, 5'd0, 1'b0);
    tick();
    checkOutput("sh_be",    dmem_be,    4'b1100);
    checkOutput("sh_wdata", dmem_wdata, 32'h12341234);
    checkOutput("sh_addr",  dmem_addr,  32'h2004);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    applyNop();

    $display("[TB] LHU to x0 and LH sign extension");
    applyStimulus(2'b01, 1'b0, 3'b101, 2'b00, 32'h10, 32'h0, 32'h0, 5'd0, 1'b1);
    dmem_rdata = 32'hBEEF8001;
    tick();
    checkOutput("lhu_req",  dmem_req,  1);
    checkOutput("lhu_addr", dmem_addr, 32'h10);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    applyNop();
    checkOutput("lhu_wb", wb_data_out,  32'h00008001);
    checkOutput("lhu_rw", Regwrite_out, 0);

    applyStimulus(2'b01, 1'b0, 3'b001, 2'b00, 32'h12, 32'h0, 32'h0, 5'd9, 1'b1);
    dmem_rdata = 32'h8001BEEF;
    tick();
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    applyNop();
    checkOutput("lh_wb", wb_data_out,  32'hFFFF8001);
    checkOutput("lh_rw", Regwrite_out, 1);

    $display("[TB] reset during REQ with late ack");
    applyStimulus(2'b01, 1'b0, 3'b010, 2'b00, 32'h300, 32'h0, 32'h0, 5'd4, 1'b1);
    tick();
    checkOutput("rq_req", dmem_req, 1);
    rst = 1'b1;
    tick();
    checkOutput("rq_req_rst",  dmem_req,      0);
    checkOutput("rq_addr_rst", dmem_addr,     0);
    checkOutput("rq_wb_rst",   wb_data_out,   0);
    checkOutput("rq_regd_rst", regdindex_out, 0);
    rst = 1'b0;
    applyNop();
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    checkOutput("rq_req_late",   dmem_req,     0);
    checkOutput("rq_we_late",    dmem_we,      0);
    checkOutput("rq_be_late",    dmem_be,      0);
    checkOutput("rq_wdata_late", dmem_wdata,   0);
    checkOutput("rq_wb_late",    wb_data_out,  0);
    checkOutput("rq_rw_late",    Regwrite_out, 0);
    checkOutput("rq_stall_late", mem_stall,    0);

    $display("[TB] misaligned LW at 0x102");
    applyStimulus(2'b01, 1'b0, 3'b010, 2'b00, 32'h102, 32'h0, 32'h0, 5'd6, 1'b1);
    dmem_rdata = 32'hCAFEF00D;
`ifdef MEM_MISALIGN_TRAP_EN
    #1 checkOutput("mis_stall", mem_stall, 0);
    checkOutput("mis_req0", dmem_req, 0);
    tick();
    applyNop();
    checkOutput("mis_err", misalign_err, 1);
    checkOutput("mis_rw",  Regwrite_out, 0);
    checkOutput("mis_req", dmem_req,     0);
    tick();
    checkOutput("mis_err_clr", misalign_err, 0);
`else
    #1 checkOutput("mis_stall", mem_stall, 1);
    tick();
    checkOutput("mis_req",  dmem_req,  1);
    checkOutput("mis_addr", dmem_addr, 32'h100);
    checkOutput("mis_be",   dmem_be,   4'b1111);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    applyNop();
    checkOutput("mis_wb",  wb_data_out,  32'hCAFEF00D);
    checkOutput("mis_rw",  Regwrite_out, 1);
    checkOutput("mis_err", misalign_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter datawidth, default 32, data/address width.
REQ-002 SHALL have parameter regindex, default 5, destination register index width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports ALU_in / datareg_in / pcm_in  in  datawidth each: address, store data and PC+4 from EX/MEM.
REQ-006 SHALL have ports regdindex_in  in  regindex; WBsel_in  in  2; MEMRw_in  in  1 (1=store); Rsel_in  in  3 (load funct3); Wsel_in  in  2 (store size); Regwrite_in  in  1.
REQ-007 SHALL have port mem_stall  out  1: holds EX/MEM and all upstream stages when high.
REQ-008 SHALL have ports dmem_req  out  1; dmem_we  out  1; dmem_addr  out  datawidth (word-aligned); dmem_wdata  out  datawidth; dmem_be  out  4.
REQ-009 SHALL have ports dmem_ack  in  1; dmem_rdata  in  datawidth.
REQ-010 SHALL have ports wb_data_out  out  datawidth; regdindex_out  out  regindex; Regwrite_out  out  1; misalign_err  out  1 (macro-dependent).

Function
REQ-011 SHALL decode WBsel: 00=ALU, 01=memory load, 10=PC+4, 11=ALU; memop = (WBsel_in==01) | MEMRw_in.
REQ-012 SHALL implement FSM IDLE/REQ; IDLE: memop -> latch request registers, go REQ; REQ: dmem_req=1, on dmem_ack go IDLE.
REQ-013 SHALL drive mem_stall = (IDLE & memop) | (REQ & ~dmem_ack), combinationally.
REQ-014 SHALL hold dmem_addr/we/wdata/be stable from REQ entry until the dmem_ack cycle; dmem_req SHALL be registered (low in IDLE).
REQ-015 SHALL load the MEM/WB register whenever mem_stall is low; non-memop latency 1 cycle, memop latency 1 + memory wait cycles (minimum 2).
REQ-016 SHALL insert a bubble (Regwrite_out=0, data held) into MEM/WB on every stalled cycle.
REQ-017 SHALL select wb_data: ALU_in, formatted dmem_rdata, or pcm_in per WBsel.
REQ-018 SHALL format loads by Rsel: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (sign/zero extend lane at addr[1:0]); others treated as LW.
REQ-019 SHALL encode stores by Wsel: 00 byte (be=0001<<a[1:0], data replicated x4), 01 half (be=0011<<a[1], replicated x2), 10/11 word (be=1111).
REQ-020 SHALL force Regwrite_out=0 when regdindex_in==0.
REQ-021 SHALL ignore dmem_ack while in IDLE.

Reset
REQ-022 SHALL on rst go IDLE, clear dmem_req/dmem_we/dmem_be/dmem_addr/dmem_wdata, wb_data_out, regdindex_out, Regwrite_out, misalign_err to 0, overriding everything, including mid-REQ.
REQ-023 SHALL, after rst during REQ, not retry the aborted access; a late ack is discarded.

Configuration
REQ-024 SHALL honour macro MEM_MISALIGN_TRAP_EN.
REQ-025 With MEM_MISALIGN_TRAP_EN: half at odd address or word with addr[1:0]!=0 SHALL issue no request, no stall, Regwrite_out=0, and pulse misalign_err for the cycle MEM/WB loads.
REQ-026 Without MEM_MISALIGN_TRAP_EN: misaligned low address bits SHALL be truncated to natural alignment; misalign_err SHALL be tied 0.

Structure
REQ-027 SHALL place WBsel encodings, load/store size constants and the FSM state type in package mem_stage_pkg.
REQ-028 SHALL implement load extraction/extension in sub-module mem_load_align (combinational: rdata, addr[1:0], Rsel -> data).

Verification
REQ-029 ALU op, WBsel=00, ALU_in=0x1234, regd=5 -> next edge wb_data_out=0x1234, Regwrite_out=1, mem_stall never high.
REQ-030 LB at 0x1003, rdata=0x80FF_FF_FF, ack 3 cycles after req -> stall 4 cycles, bubbles, then wb_data_out=0xFFFFFF80.
REQ-031 SB at 0x2002, datareg_in=0x000000AB, ack same cycle as req -> dmem_be=0100, dmem_wdata=0xABABABAB, dmem_addr=0x2000, dmem_we=1, Regwrite_out=0.
REQ-032 LHU at 0x10, rdata=0xBEEF8001, regd=0 -> wb_data_out=0x00008001, Regwrite_out=0.
REQ-033 rst asserted during REQ, ack arrives 1 cycle later -> dmem_req=0 after edge, ack ignored, all outputs 0.
REQ-034 LW at 0x102 with MEM_MISALIGN_TRAP_EN -> no dmem_req, misalign_err=1 one cycle; without macro -> dmem_addr=0x100 access.
